// File: rtl/ur_burst_arbiter.sv
// ============================================================================
// ur_burst_arbiter : round-robin burst arbiter sharing the UR read port
// Optional beat statistics counter enabled by `define UR_ARB_STATS_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module ur_burst_arbiter #(
    parameter int NUM_REQ    = 6,
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 11,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*4-1:0]            req_id,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
    output logic                            ur_re,
    output logic [3:0]                      ur_id,
    output logic [ADDR_WIDTH-1:0]           ur_addr,
    input  logic [DATA_WIDTH-1:0]           ur_rdata,
    output logic                            rsp_valid,
    output logic [NUM_REQ-1:0]              rsp_sel,
    output logic [DATA_WIDTH-1:0]           rsp_data,
    output logic                            rsp_last,
    output logic                            busy,
    output logic [31:0]                     beat_count
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [PTR_W-1:0]        r_ptr, w_gnt_idx, w_k;
    logic                    w_gnt_found, w_hs;
    logic [3:0]              w_id;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [LEN_WIDTH-1:0]    w_len;
    logic [LEN_WIDTH-1:0]    r_left;
    logic [NUM_REQ-1:0]      r_sel;
    logic                    r_ur_re, r_ur_last;
    logic [3:0]              r_ur_id;
    logic [ADDR_WIDTH-1:0]   r_ur_addr;
    logic                    r_rsp_valid, r_rsp_last;
    logic [NUM_REQ-1:0]      r_rsp_sel;

    // Round-robin search starting just after the last winner
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_k         = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_k = PTR_W'((int'(r_ptr) + i) % NUM_REQ);
            if (!w_gnt_found && req_valid[w_k]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_k;
            end
        end
    end

    always_comb begin
        w_id   = '0;
        w_addr = '0;
        w_len  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_gnt_idx == PTR_W'(j)) begin
                w_id   = req_id[j*4 +: 4];
                w_addr = req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
                w_len  = req_len[j*LEN_WIDTH +: LEN_WIDTH];
            end
        end
    end

    assign w_hs      = (r_state == S_IDLE) && w_gnt_found;
    assign req_ready = w_hs ? (NUM_REQ'(1) << w_gnt_idx) : '0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_hs) w_state_nxt = S_ISSUE;
            S_ISSUE: if (r_left == '0) w_state_nxt = S_DRAIN;
            S_DRAIN: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // r_left counts beats still to issue after the one currently on ur_re
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= PTR_W'(NUM_REQ - 1);
            r_sel       <= '0;
            r_left      <= '0;
            r_ur_re     <= 1'b0;
            r_ur_last   <= 1'b0;
            r_ur_id     <= '0;
            r_ur_addr   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_sel   <= '0;
            r_rsp_last  <= 1'b0;
        end else begin
            r_rsp_valid <= r_ur_re;
            r_rsp_sel   <= r_ur_re ? r_sel : '0;
            r_rsp_last  <= r_ur_re & r_ur_last;
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_ptr     <= w_gnt_idx;
                        r_sel     <= NUM_REQ'(1) << w_gnt_idx;
                        r_ur_re   <= 1'b1;
                        r_ur_id   <= w_id;
                        r_ur_addr <= w_addr;
                        r_left    <= w_len;
                        r_ur_last <= (w_len == '0);
                    end
                end
                S_ISSUE: begin
                    if (r_left == '0) begin
                        r_ur_re   <= 1'b0;
                        r_ur_last <= 1'b0;
                    end else begin
                        r_ur_addr <= r_ur_addr + 1'b1;
                        r_left    <= r_left - 1'b1;
                        r_ur_last <= (r_left == LEN_WIDTH'(1));
                    end
                end
                default: ;
            endcase
        end
    end

    assign ur_re     = r_ur_re;
    assign ur_id     = r_ur_id;
    assign ur_addr   = r_ur_addr;
    assign rsp_valid = r_rsp_valid;
    assign rsp_sel   = r_rsp_sel;
    assign rsp_last  = r_rsp_last;
    assign rsp_data  = r_rsp_valid ? ur_rdata : '0;
    assign busy      = (r_state != S_IDLE);

`ifdef UR_ARB_STATS_EN
    logic [31:0] r_beat_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_beat_count <= '0;
        else if (r_ur_re) r_beat_count <= r_beat_count + 32'd1;
    end

    assign beat_count = r_beat_count;
`else
    assign beat_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ur_burst_arbiter.sv
// ============================================================================
// tb_ur_burst_arbiter : directed scoreboard bench for ur_burst_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ur_burst_arbiter;

    typedef struct packed {
        logic [10:0] addr;
        logic [3:0]  id;
        logic [5:0]  sel;
        logic        last;
    } iss_t;

    typedef struct packed {
        logic [5:0]   sel;
        logic         last;
        logic [127:0] data;
    } rsp_t;

`ifdef UR_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic [5:0]   req_valid;
    logic [5:0]   req_ready;
    logic [23:0]  req_id;
    logic [65:0]  req_addr;
    logic [23:0]  req_len;
    logic         ur_re;
    logic [3:0]   ur_id;
    logic [10:0]  ur_addr;
    logic [127:0] ur_rdata;
    logic         rsp_valid;
    logic [5:0]   rsp_sel;
    logic [127:0] rsp_data;
    logic         rsp_last;
    logic         busy;
    logic [31:0]  beat_count;

    logic [3:0]   c_id   [6];
    logic [10:0]  c_addr [6];
    logic [3:0]   c_len  [6];

    iss_t         iss_q [$];
    rsp_t         rsp_q [$];
    int           exp_g [$];
    int           hs_cyc_q [$];
    logic [127:0] pend_d;
    logic         pend_v;
    int           n_cmp, n_err, cyc, n_re, n_rsp, rdy2_cnt;
    logic         rdy4_seen;

    ur_burst_arbiter #(
        .NUM_REQ(6), .DATA_WIDTH(128), .ADDR_WIDTH(11), .LEN_WIDTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_id(req_id), .req_addr(req_addr), .req_len(req_len),
        .ur_re(ur_re), .ur_id(ur_id), .ur_addr(ur_addr), .ur_rdata(ur_rdata),
        .rsp_valid(rsp_valid), .rsp_sel(rsp_sel), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .busy(busy), .beat_count(beat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 6; i++) begin
            req_id[i*4 +: 4]    = c_id[i];
            req_addr[i*11 +: 11] = c_addr[i];
            req_len[i*4 +: 4]   = c_len[i];
        end
    end

    function automatic logic [127:0] mk_data(input logic [10:0] a, input logic [3:0] i);
        return {21'h0, a, 28'h0, i, 32'hC0DE_0000 + {21'h0, a}, 32'h1234_5678 ^ {17'h0, i, a}};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: record handshakes, drive the UR memory model, score outputs
    task automatic tick();
        logic [5:0] hs;
        int         g;
        iss_t       e;
        rsp_t       r;
        #1;
        hs = req_valid & req_ready;
        if (req_ready[2]) rdy2_cnt++;
        if (req_ready[4]) rdy4_seen = 1'b1;
        chk("ready_onehot0", {127'h0, $onehot0(req_ready)}, 128'h1);
        if (hs != 6'h0) begin
            g = -1;
            for (int b = 0; b < 6; b++) if (hs[b] && g < 0) g = b;
            if (exp_g.size() == 0) chk("grant_unexpected", {122'h0, hs}, 128'h0);
            else chk("grant_order", g, exp_g.pop_front());
            hs_cyc_q.push_back(cyc);
            for (int k = 0; k <= int'(c_len[g]); k++) begin
                e.addr = c_addr[g] + 11'(k);
                e.id   = c_id[g];
                e.sel  = 6'(1 << g);
                e.last = (k == int'(c_len[g]));
                iss_q.push_back(e);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        req_valid = req_valid & ~hs;
        if (pend_v) ur_rdata = pend_d;
        else        ur_rdata = {$urandom, $urandom, $urandom, $urandom};
        pend_v = 1'b0;
        #1;
        if (rsp_valid) begin
            n_rsp++;
            if (rsp_q.size() == 0) chk("rsp_unexpected", {127'h0, rsp_valid}, 128'h0);
            else begin
                r = rsp_q.pop_front();
                chk("rsp_sel", {122'h0, rsp_sel}, {122'h0, r.sel});
                chk("rsp_last", {127'h0, rsp_last}, {127'h0, r.last});
                chk("rsp_data", rsp_data, r.data);
            end
        end else begin
            chk("rsp_sel_idle", {122'h0, rsp_sel}, 128'h0);
            chk("rsp_last_idle", {127'h0, rsp_last}, 128'h0);
        end
        chk("beat_count", {96'h0, beat_count}, STATS ? n_re : 0);
        if (ur_re) begin
            n_re++;
            if (iss_q.size() == 0) chk("ur_re_unexpected", {127'h0, ur_re}, 128'h0);
            else begin
                e = iss_q.pop_front();
                chk("ur_addr", {117'h0, ur_addr}, {117'h0, e.addr});
                chk("ur_id", {124'h0, ur_id}, {124'h0, e.id});
                pend_d = mk_data(ur_addr, ur_id);
                pend_v = 1'b1;
                r.sel  = e.sel;
                r.last = e.last;
                r.data = pend_d;
                rsp_q.push_back(r);
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((exp_g.size() != 0 || iss_q.size() != 0 || rsp_q.size() != 0 ||
                    pend_v || busy) && n < 300);
        chk("drain_outstanding", exp_g.size() + iss_q.size() + rsp_q.size(), 0);
        chk("idle_busy", {127'h0, busy}, 128'h0);
    endtask

    task automatic clear_sb();
        iss_q.delete();
        rsp_q.delete();
        exp_g.delete();
        hs_cyc_q.delete();
        pend_v = 1'b0;
    endtask

    // Asserted away from the clock edge; requests are raised after release
    task automatic do_reset(input logic [5:0] v);
        rst_n     = 1'b0;
        req_valid = 6'h0;
        clear_sb();
        repeat (2) @(posedge clk);
        #3;
        rst_n     = 1'b1;
        n_re      = 0;
        req_valid = v;
    endtask

    task automatic set_cmd(input int r, input logic [3:0] id, input logic [10:0] a, input logic [3:0] l);
        c_id[r]   = id;
        c_addr[r] = a;
        c_len[r]  = l;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0; n_re = 0; n_rsp = 0; rdy2_cnt = 0;
        rdy4_seen = 1'b0; pend_v = 1'b0; pend_d = '0;
        rst_n = 1'b0; req_valid = 6'h0; ur_rdata = '0;
        for (int i = 0; i < 6; i++) set_cmd(i, 4'h0, 11'h0, 4'h0);

        // Reset values
        #2;
        chk("rst_ur_re", {127'h0, ur_re}, 128'h0);
        chk("rst_ur_id", {124'h0, ur_id}, 128'h0);
        chk("rst_ur_addr", {117'h0, ur_addr}, 128'h0);
        chk("rst_rsp_valid", {127'h0, rsp_valid}, 128'h0);
        chk("rst_rsp_sel", {122'h0, rsp_sel}, 128'h0);
        chk("rst_busy", {127'h0, busy}, 128'h0);
        chk("rst_beat_count", {96'h0, beat_count}, 128'h0);
        do_reset(6'h0);

        // Single burst from requester 2
        set_cmd(2, 4'd5, 11'h020, 4'd3);
        rdy2_cnt = 0; n_rsp = 0;
        req_valid = 6'b000100;
        exp_g.push_back(2);
        wait_idle();
        chk("single_ready_cycles", rdy2_cnt, 1);
        chk("single_ur_re_cycles", n_re, 4);
        chk("single_rsp_cycles", n_rsp, 4);

        // Round-robin across all six from reset
        for (int i = 0; i < 6; i++) set_cmd(i, 4'(i), 11'(11'h100 + i), 4'd0);
        do_reset(6'b111111);
        for (int i = 0; i < 6; i++) exp_g.push_back(i);
        wait_idle();
        chk("rr_handshakes", hs_cyc_q.size(), 6);
        for (int i = 0; i + 1 < hs_cyc_q.size(); i++)
            chk("rr_spacing", hs_cyc_q[i+1] - hs_cyc_q[i], 3);
        req_valid = 6'b010001;
        exp_g.push_back(0);
        exp_g.push_back(4);
        wait_idle();

        // Address wrap
        set_cmd(0, 4'd7, 11'h7FE, 4'd3);
        req_valid = 6'b000001;
        exp_g.push_back(0);
        wait_idle();

        // Withdraw and priority: pointer at 3, requester 4 withdraws, 1 wins
        set_cmd(3, 4'd3, 11'h040, 4'd5);
        set_cmd(1, 4'd1, 11'h050, 4'd1);
        set_cmd(4, 4'd4, 11'h060, 4'd2);
        req_valid = 6'b001000;
        exp_g.push_back(3);
        tick();
        tick();
        rdy4_seen = 1'b0;
        req_valid = req_valid | 6'b010010;
        exp_g.push_back(1);
        tick();
        tick();
        req_valid[4] = 1'b0;
        wait_idle();
        chk("withdraw_ready4", {127'h0, rdy4_seen}, 128'h0);

        // Reset mid-burst
        begin
            int base, n;
            set_cmd(1, 4'd9, 11'h300, 4'd15);
            req_valid = 6'b000010;
            exp_g.push_back(1);
            base = n_re;
            n = 0;
            while (n_re - base < 6 && n < 50) begin
                tick();
                n++;
            end
            chk("midrst_beats", n_re - base, 6);
            #1;
            rst_n = 1'b0;
            #1;
            chk("midrst_ur_re", {127'h0, ur_re}, 128'h0);
            chk("midrst_rsp_valid", {127'h0, rsp_valid}, 128'h0);
            chk("midrst_rsp_sel", {122'h0, rsp_sel}, 128'h0);
            chk("midrst_busy", {127'h0, busy}, 128'h0);
            set_cmd(0, 4'd2, 11'h010, 4'd1);
            set_cmd(1, 4'd9, 11'h300, 4'd0);
            do_reset(6'b000011);
            exp_g.push_back(0);
            exp_g.push_back(1);
            wait_idle();
        end

        // Beat statistics: 4 + 1 + 16 beats
        do_reset(6'h0);
        set_cmd(2, 4'd1, 11'h000, 4'd3);
        req_valid = 6'b000100; exp_g.push_back(2); wait_idle();
        set_cmd(2, 4'd1, 11'h100, 4'd0);
        req_valid = 6'b000100; exp_g.push_back(2); wait_idle();
        set_cmd(2, 4'd1, 11'h200, 4'd15);
        req_valid = 6'b000100; exp_g.push_back(2); wait_idle();
        chk("stats_tb_beats", n_re, 21);
        chk("stats_beat_count", {96'h0, beat_count}, STATS ? 21 : 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ur_burst_arbiter.md
Name: ur_burst_arbiter

Overview:
- Shares the single UR random-data read port (ur_re/ur_id/ur_addr/ur_rdata) among NUM_REQ burst_store requesters (one per SMC).
- Accepts burst read commands (id, start address, beat count), arbitrates round-robin at burst granularity, and sequences one ur_re beat per cycle.
- Routes each returned ur_rdata beat back to the owning requester, tagged with a one-hot select and a last flag.

Parameters:
NUM_REQ, 6, number of requesters (2..16)
DATA_WIDTH, 128, UR data width
ADDR_WIDTH, 11, UR address width
LEN_WIDTH, 4, burst length field; beats = req_len+1 (1..2^LEN_WIDTH)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester command valid
req_ready  out  NUM_REQ  per-requester command accept (one-hot or zero)
req_id  in  NUM_REQ*4  packed UR stream id per requester
req_addr  in  NUM_REQ*ADDR_WIDTH  packed start address
req_len  in  NUM_REQ*LEN_WIDTH  packed beats-1
ur_re  out  1  UR read enable
ur_id  out  4  UR stream id
ur_addr  out  ADDR_WIDTH  UR address
ur_rdata  in  DATA_WIDTH  UR read data, valid the cycle after ur_re
rsp_valid  out  1  response beat valid
rsp_sel  out  NUM_REQ  one-hot owner of response beat
rsp_data  out  DATA_WIDTH  response data
rsp_last  out  1  final beat of burst
busy  out  1  high in any state other than IDLE
beat_count  out  32  total issued beats (see Optional Feature)

Behaviour:
- Clock and reset: one clock clk; reset rst_n asynchronous, active-low.
- Reset values:
  - ur_re=0, ur_id=0, ur_addr=0, rsp_valid=0, rsp_sel=0, rsp_last=0, busy=0, beat_count=0.
  - FSM=IDLE; RR pointer=NUM_REQ-1, so requester 0 wins first.
  - Reset mid-burst abandons the burst immediately; no further ur_re or rsp beats.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - Grant g = first requester with req_valid set, searching from pointer+1 upward, modulo NUM_REQ.
  - req_ready[g] is combinational and asserted only in IDLE. All other req_ready bits are 0.
  - On the handshake edge T: latch id/addr/len of g; latch sel=1<<g; pointer<=g; go ISSUE.
- ISSUE:
  - ur_re, ur_id, ur_addr are registered. Beat k (k=0..len) drives ur_re=1 at cycle T+1+k.
  - ur_addr = (addr+k) mod 2^ADDR_WIDTH; wraps 0x7FF -> 0x000 with no error.
  - ur_id is constant for the burst.
  - After beat len is issued, go DRAIN; ur_re deasserts.
- DRAIN: lasts one cycle, covering the final data return, then IDLE. The earliest next handshake is cycle T+len+3.
- Response path:
  - rsp_valid = ur_re delayed 1 cycle; rsp_sel and rsp_last are delayed the same way.
  - rsp_data = ur_rdata combinationally, during rsp_valid.
  - rsp_last is high only with the beat-len response.
  - rsp_sel is 0 whenever rsp_valid=0.
- Command retention: a requester must hold req_valid/id/addr/len stable until req_ready. Deasserting req_valid before grant withdraws the request with no side effects.
- Fairness: strict round-robin over bursts, so a requester waits at most NUM_REQ-1 bursts. A lone requester is re-granted every burst.
- ur_id values ≥ MAX_ID of the UR are passed through unchecked.

Optional Feature:
- Macro: UR_ARB_STATS_EN.
- When defined: beat_count increments by 1 on every cycle ur_re=1, wrapping at 2^32. It resets only via rst_n.
- When undefined: beat_count is tied to 0 and no counter logic is generated. The port exists in both builds.

Test Plan:
- Single burst:
  - Stimulus: requester 2 only, id=5, addr=0x020, len=3.
  - Required: req_ready[2] for exactly 1 cycle; ur_re high 4 cycles with ur_addr 0x020,0x021,0x022,0x023 and ur_id=5.
  - Required: rsp_valid 4 cycles one cycle later, rsp_sel=6'b000100, rsp_last on the 4th beat only; rsp_data equals the ur_rdata samples.
- Round-robin:
  - Stimulus: all 6 requesters valid from reset, len=0 each, ids 0..5.
  - Required: grants in order 0,1,2,3,4,5; each single beat; handshakes spaced 3 cycles apart.
  - Required: re-asserting requester 0 after 5 is granted next.
- Address wrap:
  - Stimulus: addr=0x7FE, len=3.
  - Required: ur_addr sequence 0x7FE,0x7FF,0x000,0x001; rsp_last on the 0x001 return.
- Reset mid-burst:
  - Stimulus: len=15 burst from requester 1; drop rst_n after beat 5.
  - Required: ur_re and rsp_valid go 0 asynchronously; FSM returns to IDLE.
  - Required: after release with requesters 1 and 0 valid, requester 0 is granted first.
- Withdraw and priority:
  - Stimulus: requester 3 busy in a burst; requester 4 asserts then drops req_valid before IDLE; requester 1 stays valid.
  - Required: requester 1 is granted next; requester 4 never sees req_ready.
- Stats, with UR_ARB_STATS_EN:
  - Stimulus: bursts of len 3, 0, 15.
  - Required: beat_count=21 after the bursts; in a build without UR_ARB_STATS_EN, beat_count stays 0.
